instr_fetch: RTL and testbench

- Fetch stage directly upstream of the instruction decoder.
- Owns the program counter and fetches one 32-bit word per instruction from instruction memory over a req/ack handshake.
- Presents the fetched word, its PC and PC+4 to the decoder over a valid/ready handshake.
- Computes redirect targets from the decoder's Imm/Jumpt fields. Flushes in-flight and buffered instructions on redirect.

---
 rtl/instr_fetch.sv | 167 ++++++++++++++++
 tb/tb_instr_fetch.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// instr_fetch: fetch stage feeding the instruction decoder.
// Owns the PC and fetches one word per instruction over a req/ack memory
// handshake. The fetched word, its PC and PC+4 go to the decoder over a
// valid/ready handshake. Redirects from downstream flush whatever is in
// flight or buffered.
//
// Ports:
//   CLK, RST                 clock, synchronous active-high reset
//   IMemReq/IMemAddr         memory request and word-aligned address (out)
//   IMemAck/IMemData         memory response and instruction word (in)
//   Instr/PCOut/PCPlus4      buffered instruction, its PC and PC+4 (out)
//   InstrValid/DecReady      decoder handshake
//   Redirect/RedirType       redirect pulse and kind (01 br, 10 j, 11 jr)
//   RedirPC/Imm/Jumpt        redirecting PC, branch offset, jump field
//   RegTarget                jump-register target
module instr_fetch #(
    parameter int unsigned   WL       = 32,
    parameter logic [WL-1:0] RESET_PC = '0
) (
    input  logic          CLK,
    input  logic          RST,
    output logic          IMemReq,
    output logic [WL-1:0] IMemAddr,
    input  logic          IMemAck,
    input  logic [WL-1:0] IMemData,
    output logic [WL-1:0] Instr,
    output logic [WL-1:0] PCOut,
    output logic [WL-1:0] PCPlus4,
    output logic          InstrValid,
    input  logic          DecReady,
    input  logic          Redirect,
    input  logic [1:0]    RedirType,
    input  logic [WL-1:0] RedirPC,
    input  logic [15:0]   Imm,
    input  logic [25:0]   Jumpt,
    input  logic [WL-1:0] RegTarget
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_KILL  = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;

    localparam logic [1:0] RT_NONE   = 2'b00;
    localparam logic [1:0] RT_BRANCH = 2'b01;
    localparam logic [1:0] RT_JUMP   = 2'b10;

    localparam int unsigned SEXT_W = WL - 18;

    logic [1:0]    state_q;
    logic [1:0]    state_d;
    logic [WL-1:0] pc_q;
    logic [WL-1:0] pc_d;

    logic          imemreq_d;
    logic [WL-1:0] imemaddr_d;
    logic [WL-1:0] instr_d;
    logic [WL-1:0] pcout_d;
    logic [WL-1:0] pcplus4_d;
    logic          instrvalid_d;

    logic          redir_eff_c;
    logic [WL-1:0] redir_pc4_c;
    logic [WL-1:0] branch_off_c;
    logic [WL-1:0] target_c;

    // Redirect target; type 00 is not a redirect, so the default is jr.
    always_comb begin
        redir_eff_c  = Redirect && (RedirType != RT_NONE);
        redir_pc4_c  = RedirPC + WL'(4);
        branch_off_c = {{SEXT_W{Imm[15]}}, Imm, 2'b00};
        case (RedirType)
            RT_BRANCH: target_c = redir_pc4_c + branch_off_c;
            RT_JUMP:   target_c = {redir_pc4_c[WL-1 -: 4], Jumpt, 2'b00};
            default:   target_c = {RegTarget[WL-1:2], 2'b00};
        endcase
    end

    // Next state, next PC and next values of the registered outputs.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = Instr;
        pcout_d   = PCOut;
        pcplus4_d = PCPlus4;

        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
                if (redir_eff_c) begin
                    pc_d = target_c;
                end
            end
            S_FETCH: begin
                if (redir_eff_c) begin
                    // Without an ack the request must finish at its old
                    // address; with one, the data is simply dropped.
                    pc_d    = target_c;
                    state_d = IMemAck ? S_FETCH : S_KILL;
                end else if (IMemAck) begin
                    instr_d   = IMemData;
                    pcout_d   = pc_q;
                    pcplus4_d = pc_q + WL'(4);
                    state_d   = S_HOLD;
                end
            end
            S_KILL: begin
                if (redir_eff_c) begin
                    pc_d = target_c;
                end
                if (IMemAck) begin
                    state_d = S_FETCH;
                end
            end
            S_HOLD: begin
                // A redirect comes from an older, already-accepted
                // instruction, so it wins over the decoder accepting.
                if (redir_eff_c) begin
                    pc_d    = target_c;
                    state_d = S_FETCH;
                end else if (DecReady) begin
                    pc_d    = pc_q + WL'(4);
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        imemreq_d    = (state_d == S_FETCH) || (state_d == S_KILL);
        // In KILL the address register keeps the abandoned fetch address.
        imemaddr_d   = (state_d == S_KILL) ? IMemAddr : pc_d;
        instrvalid_d = (state_d == S_HOLD);
    end

    // State and PC registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // Registered outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            IMemReq    <= 1'b0;
            IMemAddr   <= RESET_PC;
            Instr      <= '0;
            PCOut      <= '0;
            PCPlus4    <= '0;
            InstrValid <= 1'b0;
        end else begin
            IMemReq    <= imemreq_d;
            IMemAddr   <= imemaddr_d;
            Instr      <= instr_d;
            PCOut      <= pcout_d;
            PCPlus4    <= pcplus4_d;
            InstrValid <= instrvalid_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Testbench for instr_fetch: memory model with configurable wait states,
// cycle-level reference model, redirect target table, directed corner
// sequences and a randomized run.
module tb_instr_fetch;

    logic        CLK;
    logic        RST;
    logic        IMemReq;
    logic [31:0] IMemAddr;
    logic        IMemAck;
    logic [31:0] IMemData;
    logic [31:0] Instr;
    logic [31:0] PCOut;
    logic [31:0] PCPlus4;
    logic        InstrValid;
    logic        DecReady;
    logic        Redirect;
    logic [1:0]  RedirType;
    logic [31:0] RedirPC;
    logic [15:0] Imm;
    logic [25:0] Jumpt;
    logic [31:0] RegTarget;

    instr_fetch #(.WL(32), .RESET_PC(32'h0000_0000)) dut (
        .CLK(CLK), .RST(RST),
        .IMemReq(IMemReq), .IMemAddr(IMemAddr),
        .IMemAck(IMemAck), .IMemData(IMemData),
        .Instr(Instr), .PCOut(PCOut), .PCPlus4(PCPlus4),
        .InstrValid(InstrValid), .DecReady(DecReady),
        .Redirect(Redirect), .RedirType(RedirType), .RedirPC(RedirPC),
        .Imm(Imm), .Jumpt(Jumpt), .RegTarget(RegTarget)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Memory environment.
    int          mem_cnt   = 0;
    int          mem_ws    = 0;
    int          fixed_ws  = 0;
    bit          rand_ws   = 1'b0;
    logic        stray_ack = 1'b0;
    logic [31:0] salt      = 32'h0;

    // Reference model.
    typedef enum int {M_IDLE, M_FETCH, M_KILL, M_HOLD} mph_t;
    mph_t        m_ph    = M_IDLE;
    logic [31:0] m_pc    = 32'h0;
    logic [31:0] m_kaddr = 32'h0;
    logic [31:0] m_instr = 32'h0;
    logic [31:0] m_pcout = 32'h0;
    logic [31:0] m_pcp4  = 32'h0;

    typedef struct {
        logic [1:0]  rtype;
        logic [31:0] rpc;
        logic [15:0] imm;
        logic [25:0] jt;
        logic [31:0] rt;
        logic [31:0] exp;
    } redir_vec_t;
    redir_vec_t tbl[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] redir_target(input logic [1:0] ty, input logic [31:0] rp,
                                                 input logic [15:0] im, input logic [25:0] jt,
                                                 input logic [31:0] rt);
        int off;
        case (ty)
            2'b01: begin
                off = int'($signed(im)) * 4;
                return rp + 32'd4 + 32'(off);
            end
            2'b10:   return ((rp + 32'd4) & 32'hF000_0000) | (32'(jt) * 32'd4);
            default: return rt & 32'hFFFF_FFFC;
        endcase
    endfunction

    function automatic int pick_ws();
        return rand_ws ? int'($urandom_range(0, 3)) : fixed_ws;
    endfunction

    function automatic bit mem_will_ack();
        return IMemReq && (mem_cnt == mem_ws + 1);
    endfunction

    task automatic model_step(input logic rst, input logic ack, input logic [31:0] data);
        logic        eff;
        logic [31:0] t;
        eff = Redirect && (RedirType != 2'b00);
        t   = redir_target(RedirType, RedirPC, Imm, Jumpt, RegTarget);
        if (rst) begin
            m_ph = M_IDLE; m_pc = 32'h0; m_instr = 32'h0; m_pcout = 32'h0; m_pcp4 = 32'h0;
        end else begin
            case (m_ph)
                M_IDLE: begin
                    if (eff) m_pc = t;
                    m_ph = M_FETCH;
                end
                M_FETCH: begin
                    if (eff) begin
                        if (!ack) m_kaddr = m_pc;
                        m_pc = t;
                        m_ph = ack ? M_FETCH : M_KILL;
                    end else if (ack) begin
                        m_instr = data; m_pcout = m_pc; m_pcp4 = m_pc + 32'd4;
                        m_ph = M_HOLD;
                    end
                end
                M_KILL: begin
                    if (eff) m_pc = t;
                    if (ack) m_ph = M_FETCH;
                end
                default: begin
                    if (eff) begin
                        m_pc = t; m_ph = M_FETCH;
                    end else if (DecReady) begin
                        m_pc = m_pc + 32'd4; m_ph = M_FETCH;
                    end
                end
            endcase
        end
    endtask

    task automatic check_outputs();
        chk("req",     32'(IMemReq),    32'((m_ph == M_FETCH) || (m_ph == M_KILL)));
        chk("addr",    IMemAddr,        (m_ph == M_KILL) ? m_kaddr : m_pc);
        chk("valid",   32'(InstrValid), 32'(m_ph == M_HOLD));
        chk("instr",   Instr,           m_instr);
        chk("pcout",   PCOut,           m_pcout);
        chk("pcplus4", PCPlus4,         m_pcp4);
    endtask

    // One clock: memory response, model update, edge, bookkeeping, compare.
    task automatic cycle();
        logic pre_req;
        logic mem_ack;
        pre_req  = IMemReq;
        mem_ack  = mem_will_ack();
        IMemAck  = mem_ack | stray_ack;
        IMemData = IMemAddr ^ salt;
        model_step(RST, IMemAck, IMemData);
        @(posedge CLK);
        #1;
        cyc++;
        if (pre_req && !mem_ack) begin
            mem_cnt++;
        end else begin
            mem_cnt = 0;
            mem_ws  = pick_ws();
        end
        check_outputs();
    endtask

    task automatic do_reset(input int n);
        RST = 1'b1; Redirect = 1'b0; stray_ack = 1'b0;
        repeat (n) cycle();
        RST = 1'b0;
    endtask

    task automatic wait_valid(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (InstrValid) break;
            cycle();
        end
        chk("wait_valid", 32'(InstrValid), 32'd1);
    endtask

    task automatic jr_redirect(input logic [31:0] tgt);
        Redirect = 1'b1; RedirType = 2'b11; RegTarget = tgt;
        cycle();
        Redirect = 1'b0;
    endtask

    initial begin
        logic [31:0] addrs[3];
        int          nreq;
        int          vcyc[$];
        bit          got_ack;

        RST = 1'b1; IMemAck = 1'b0; IMemData = 32'h0; DecReady = 1'b0;
        Redirect = 1'b0; RedirType = 2'b00; RedirPC = 32'h0; Imm = 16'h0;
        Jumpt = 26'h0; RegTarget = 32'h0;

        tbl[0] = '{2'b01, 32'h0000_0100, 16'hFFFE, 26'h0,       32'h0,         32'h0000_00FC};
        tbl[1] = '{2'b10, 32'h1000_0040, 16'h0,    26'h0000100, 32'h0,         32'h1000_0400};
        tbl[2] = '{2'b11, 32'h0,         16'h0,    26'h0,       32'h0000_2003, 32'h0000_2000};
        tbl[3] = '{2'b01, 32'hFFFF_FFF8, 16'h0001, 26'h0,       32'h0,         32'h0000_0000};
        tbl[4] = '{2'b01, 32'h0000_0010, 16'h7FFF, 26'h0,       32'h0,         32'h0002_0010};
        tbl[5] = '{2'b01, 32'h0000_0000, 16'h8000, 26'h0,       32'h0,         32'hFFFE_0004};
        tbl[6] = '{2'b10, 32'hF000_0000, 16'h0,    26'h3FFFFFF, 32'h0,         32'hFFFF_FFFC};
        tbl[7] = '{2'b10, 32'hEFFF_FFFC, 16'h0,    26'h0000001, 32'h0,         32'hF000_0004};
        tbl[8] = '{2'b11, 32'h0,         16'h0,    26'h0,       32'hFFFF_FFFF, 32'hFFFF_FFFC};

        // Reset, then sequential fetch with zero-wait memory.
        fixed_ws = 0;
        do_reset(2);
        chk("rst_req",   32'(IMemReq),    32'd0);
        chk("rst_addr",  IMemAddr,        32'h0);
        chk("rst_instr", Instr,           32'h0);
        chk("rst_pcout", PCOut,           32'h0);
        chk("rst_pcp4",  PCPlus4,         32'h0);
        chk("rst_valid", 32'(InstrValid), 32'd0);
        DecReady = 1'b1;
        nreq = 0;
        for (int i = 0; i < 12; i++) begin
            cycle();
            if (IMemReq && mem_cnt == 0 && nreq < 3) begin
                addrs[nreq] = IMemAddr;
                nreq++;
            end
            if (InstrValid) vcyc.push_back(cyc);
        end
        chk("seq_nreq", 32'(nreq), 32'd3);
        for (int i = 0; i < nreq; i++) chk("seq_addr", addrs[i], 32'(i * 4));
        chk("seq_nvalid_ge3", 32'(vcyc.size() >= 3), 32'd1);
        for (int i = 1; i < vcyc.size(); i++) chk("seq_spacing", 32'(vcyc[i] - vcyc[i-1]), 32'd3);

        // Decoder stall while holding PC 0x4.
        do_reset(2);
        DecReady = 1'b0;
        wait_valid(20);
        DecReady = 1'b1;
        cycle();
        DecReady = 1'b0;
        wait_valid(20);
        chk("stall_pc_pre", PCOut, 32'h4);
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("stall_req",   32'(IMemReq),    32'd0);
            chk("stall_pc",    PCOut,           32'h4);
            chk("stall_instr", Instr,           32'h4);
            chk("stall_valid", 32'(InstrValid), 32'd1);
        end
        DecReady = 1'b1;
        cycle();
        chk("stall_next_req",  32'(IMemReq), 32'd1);
        chk("stall_next_addr", IMemAddr,     32'h8);

        // Redirect target table, each applied from a held instruction.
        for (int v = 0; v < 9; v++) begin
            do_reset(1);
            DecReady = 1'b0;
            wait_valid(20);
            Redirect = 1'b1; RedirType = tbl[v].rtype; RedirPC = tbl[v].rpc;
            Imm = tbl[v].imm; Jumpt = tbl[v].jt; RegTarget = tbl[v].rt;
            DecReady = 1'($urandom_range(0, 1));
            cycle();
            Redirect = 1'b0; DecReady = 1'b0;
            chk("tbl_addr",  IMemAddr,        tbl[v].exp);
            chk("tbl_req",   32'(IMemReq),    32'd1);
            chk("tbl_flush", 32'(InstrValid), 32'd0);
            wait_valid(20);
            chk("tbl_pcout", PCOut, tbl[v].exp);
        end

        // Redirect during a 3-wait-state fetch of 0x20 to 0x80.
        fixed_ws = 0;
        do_reset(1);
        DecReady = 1'b0;
        wait_valid(20);
        fixed_ws = 3;
        jr_redirect(32'h20);
        chk("kill_first_addr", IMemAddr, 32'h20);
        jr_redirect(32'h80);
        got_ack = 1'b0;
        for (int k = 0; k < 10; k++) begin
            got_ack = mem_will_ack();
            cycle();
            if (got_ack) break;
            chk("kill_addr",  IMemAddr,        32'h20);
            chk("kill_req",   32'(IMemReq),    32'd1);
            chk("kill_valid", 32'(InstrValid), 32'd0);
        end
        chk("kill_ack_seen",  32'(got_ack),     32'd1);
        chk("kill_next_addr", IMemAddr,         32'h80);
        chk("kill_no_valid",  32'(InstrValid),  32'd0);
        wait_valid(20);
        chk("kill_pcout", PCOut, 32'h80);
        chk("kill_instr", Instr, 32'h80);

        // Redirect coincident with the ack: no KILL cycle.
        fixed_ws = 0;
        do_reset(1);
        DecReady = 1'b0;
        wait_valid(20);
        jr_redirect(32'h20);
        cycle();
        chk("coinc_ack_now", 32'(mem_will_ack()), 32'd1);
        jr_redirect(32'h80);
        chk("coinc_req",   32'(IMemReq),    32'd1);
        chk("coinc_addr",  IMemAddr,        32'h80);
        chk("coinc_valid", 32'(InstrValid), 32'd0);
        wait_valid(20);
        chk("coinc_pcout", PCOut, 32'h80);

        // PC wrap from 0xFFFF_FFFC.
        do_reset(1);
        DecReady = 1'b0;
        wait_valid(20);
        jr_redirect(32'hFFFF_FFFC);
        wait_valid(20);
        chk("wrap_pcout", PCOut,   32'hFFFF_FFFC);
        chk("wrap_pcp4",  PCPlus4, 32'h0);
        DecReady = 1'b1;
        cycle();
        chk("wrap_addr", IMemAddr,     32'h0);
        chk("wrap_req",  32'(IMemReq), 32'd1);

        // Reset during a KILL wait, then a late ack while idle.
        do_reset(1);
        DecReady = 1'b0;
        wait_valid(20);
        fixed_ws = 3;
        jr_redirect(32'h40);
        jr_redirect(32'h80);
        chk("mrst_kill_addr", IMemAddr, 32'h40);
        cycle();
        RST = 1'b1;
        cycle();
        RST = 1'b0;
        chk("mrst_req",   32'(IMemReq),    32'd0);
        chk("mrst_addr",  IMemAddr,        32'h0);
        chk("mrst_valid", 32'(InstrValid), 32'd0);
        stray_ack = 1'b1;
        cycle();
        stray_ack = 1'b0;
        chk("late_ack_req",   32'(IMemReq),    32'd1);
        chk("late_ack_addr",  IMemAddr,        32'h0);
        chk("late_ack_valid", 32'(InstrValid), 32'd0);
        wait_valid(20);
        chk("late_ack_pcout", PCOut, 32'h0);

        // Randomized run against the reference model.
        salt    = $urandom;
        rand_ws = 1'b1;
        do_reset(2);
        for (int i = 0; i < 3000; i++) begin
            RST       = ($urandom_range(0, 199) == 0);
            DecReady  = ($urandom_range(0, 3) != 0);
            Redirect  = ($urandom_range(0, 9) == 0);
            RedirType = 2'($urandom_range(0, 3));
            RedirPC   = $urandom;
            Imm       = 16'($urandom);
            Jumpt     = 26'($urandom);
            RegTarget = $urandom;
            stray_ack = !IMemReq && ($urandom_range(0, 15) == 0);
            cycle();
        end
        RST = 1'b0; Redirect = 1'b0; stray_ack = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
